// File: rtl/ram_pkg.sv
// ram_pkg: shared constants for the core_ram simulation memory.
//   STDOUT_ADDR - character output peripheral (data port only)
//   EXIT_ADDR   - program-exit register (data port only)
//   INSTR_BYTES - bytes returned per instruction fetch
//   DATA_BYTES  - bytes per data-port word
package ram_pkg;
    localparam logic [31:0] STDOUT_ADDR = 32'h1000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'h2000_0000;
    localparam int          INSTR_BYTES = 16;
    localparam int          DATA_BYTES  = 4;
endpackage

// File: rtl/dp_ram.sv
// dp_ram: byte-addressed array with two ports and registered read outputs.
//   clk, rst_ni             clock, async active-low reset (read registers only;
//                           the array itself is never reset)
//   a_req_i, a_addr_i       port A fetch, line index (16-byte aligned)
//   a_rdata_o               port A read data, 16 bytes little-endian
//   b_req_i, b_we_i, b_be_i port B request, write enable, byte enables
//   b_addr_i, b_wdata_i     port B word index (4-byte aligned), write data
//   b_rdata_o               port B read data; 0 after a write or an idle cycle
module dp_ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 22
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       a_req_i,
    input  logic [ADDR_WIDTH-5:0]      a_addr_i,
    output logic [8*INSTR_BYTES-1:0]   a_rdata_o,
    input  logic                       b_req_i,
    input  logic                       b_we_i,
    input  logic [DATA_BYTES-1:0]      b_be_i,
    input  logic [ADDR_WIDTH-3:0]      b_addr_i,
    input  logic [8*DATA_BYTES-1:0]    b_wdata_i,
    output logic [8*DATA_BYTES-1:0]    b_rdata_o
);
    localparam int ALSB = $clog2(INSTR_BYTES);
    localparam int BLSB = $clog2(DATA_BYTES);

    logic [7:0] mem [2**ADDR_WIDTH];

    logic [8*INSTR_BYTES-1:0] a_rdata_d, a_rdata_q;
    logic [8*DATA_BYTES-1:0]  b_rdata_d, b_rdata_q;

    always_comb begin
        a_rdata_d = a_rdata_q;
        if (a_req_i) begin
            for (int i = 0; i < INSTR_BYTES; i++)
                a_rdata_d[8*i +: 8] = mem[{a_addr_i, ALSB'(i)}];
        end
        // Writes and idle cycles return zero so the top never has to mask.
        b_rdata_d = '0;
        if (b_req_i && !b_we_i) begin
            for (int k = 0; k < DATA_BYTES; k++)
                b_rdata_d[8*k +: 8] = mem[{b_addr_i, BLSB'(k)}];
        end
    end

    // Non-blocking update: a same-cycle port A read sees the old bytes.
    always_ff @(posedge clk) begin
        if (b_req_i && b_we_i) begin
            for (int k = 0; k < DATA_BYTES; k++)
                if (b_be_i[k]) mem[{b_addr_i, BLSB'(k)}] <= b_wdata_i[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;
endmodule

// File: rtl/core_ram.sv
// core_ram: simulation memory for the RI5CY core model.
//   clk, rst_ni          clock, async active-low reset
//   instr_*              128-bit fetch port (always reads the array)
//   data_*               32-bit byte-enabled data port with peripheral decode
//   exit_valid_o         one-cycle pulse after a write to EXIT_ADDR
//   exit_value_o         last exit code written
// Build option: RAM_STDOUT_EN - when defined, writes to STDOUT_ADDR print
// data_wdata_i[7:0] as a character; otherwise they are silently dropped.
module core_ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 22
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         instr_req_i,
    input  logic [31:0]  instr_addr_i,
    output logic         instr_gnt_o,
    output logic         instr_rvalid_o,
    output logic [127:0] instr_rdata_o,
    input  logic         data_req_i,
    input  logic [31:0]  data_addr_i,
    input  logic         data_we_i,
    input  logic [3:0]   data_be_i,
    input  logic [31:0]  data_wdata_i,
    output logic         data_gnt_o,
    output logic         data_rvalid_o,
    output logic [31:0]  data_rdata_o,
    output logic         exit_valid_o,
    output logic [31:0]  exit_value_o
);
    logic is_stdout, is_exit, is_periph;
    logic instr_rvalid_d, instr_rvalid_q;
    logic data_rvalid_d, data_rvalid_q;
    logic exit_valid_d, exit_valid_q;
    logic [31:0] exit_value_d, exit_value_q;

    // Alias bits and sub-word offsets carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH], instr_addr_i[3:0],
                                data_addr_i[1:0]};

    assign is_stdout = (data_addr_i[31:2] == STDOUT_ADDR[31:2]);
    assign is_exit   = (data_addr_i[31:2] == EXIT_ADDR[31:2]);
    assign is_periph = is_stdout | is_exit;

    assign instr_gnt_o = instr_req_i;
    assign data_gnt_o  = data_req_i;

    always_comb begin
        instr_rvalid_d = instr_req_i;
        data_rvalid_d  = data_req_i;
        exit_valid_d   = data_req_i && data_we_i && is_exit;
        exit_value_d   = exit_valid_d ? data_wdata_i : exit_value_q;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            exit_valid_q   <= 1'b0;
            exit_value_q   <= '0;
        end else begin
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            exit_valid_q   <= exit_valid_d;
            exit_value_q   <= exit_value_d;
        end
    end

    // Peripheral accesses never reach the array; a gated read request also
    // makes dp_ram return zero for peripheral reads.
    dp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_dp_ram (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .a_req_i   (instr_req_i),
        .a_addr_i  (instr_addr_i[ADDR_WIDTH-1:4]),
        .a_rdata_o (instr_rdata_o),
        .b_req_i   (data_req_i && !is_periph),
        .b_we_i    (data_we_i),
        .b_be_i    (data_be_i),
        .b_addr_i  (data_addr_i[ADDR_WIDTH-1:2]),
        .b_wdata_i (data_wdata_i),
        .b_rdata_o (data_rdata_o)
    );

`ifdef RAM_STDOUT_EN
    always_ff @(posedge clk) begin
        if (rst_ni && data_req_i && data_we_i && is_stdout)
            $write("%c", data_wdata_i[7:0]);
    end
`else
    // Stdout writes are acknowledged by the normal handshake and dropped.
`endif

    assign instr_rvalid_o = instr_rvalid_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;
endmodule

// File: tb/tb_core_ram.sv
module tb_core_ram;
    localparam int          AW   = 22;
    localparam int unsigned MASK = (32'd1 << AW) - 1;
    localparam logic [31:0] STDOUT_A = 32'h1000_0000;
    localparam logic [31:0] EXIT_A   = 32'h2000_0000;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         instr_req_i = 1'b0;
    logic [31:0]  instr_addr_i = '0;
    logic         instr_gnt_o, instr_rvalid_o;
    logic [127:0] instr_rdata_o;
    logic         data_req_i = 1'b0;
    logic [31:0]  data_addr_i = '0;
    logic         data_we_i = 1'b0;
    logic [3:0]   data_be_i = '0;
    logic [31:0]  data_wdata_i = '0;
    logic         data_gnt_o, data_rvalid_o;
    logic [31:0]  data_rdata_o;
    logic         exit_valid_o;
    logic [31:0]  exit_value_o;

    core_ram #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a sparse byte map indexed by physical address.
    logic [7:0]  ref_mem [int unsigned];
    logic [31:0] ref_exit = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int unsigned idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 8'h00;
    endfunction

    function automatic bit ref_periph(input logic [31:0] a);
        return (a[31:2] == STDOUT_A[31:2]) || (a[31:2] == EXIT_A[31:2]);
    endfunction

    function automatic logic [31:0] ref_rd32(input logic [31:0] a);
        logic [31:0] r;
        int unsigned base = (a & MASK) & ~32'd3;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_byte(base + k);
        return r;
    endfunction

    function automatic logic [127:0] ref_fetch(input logic [31:0] a);
        logic [127:0] r;
        int unsigned base = (a & MASK) & ~32'd15;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_byte(base + k);
        return r;
    endfunction

    // One request cycle on either/both ports, with the response checked one
    // cycle later against the model's pre-edge view of memory.
    task automatic do_op(input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic dwe, input logic [3:0] be,
                         input logic [31:0] daddr, input logic [31:0] wd);
        logic [127:0] exp_i;
        logic [31:0]  exp_d;
        logic         exp_ev;
        instr_req_i = ireq; instr_addr_i = iaddr;
        data_req_i = dreq; data_we_i = dwe; data_be_i = be;
        data_addr_i = daddr; data_wdata_i = wd;
        #1;
        chk("instr_gnt", {127'b0, instr_gnt_o}, {127'b0, ireq});
        chk("data_gnt", {127'b0, data_gnt_o}, {127'b0, dreq});
        exp_i  = ref_fetch(iaddr);
        exp_d  = (dreq && !dwe && !ref_periph(daddr)) ? ref_rd32(daddr) : 32'h0;
        exp_ev = dreq && dwe && (daddr[31:2] == EXIT_A[31:2]);
        if (exp_ev) ref_exit = wd;
        if (dreq && dwe && !ref_periph(daddr)) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) ref_mem[((daddr & MASK) & ~32'd3) + k] = wd[8*k +: 8];
        end
        @(posedge clk); #1;
        chk("instr_rvalid", {127'b0, instr_rvalid_o}, {127'b0, ireq});
        chk("data_rvalid", {127'b0, data_rvalid_o}, {127'b0, dreq});
        if (ireq) chk("instr_rdata", instr_rdata_o, exp_i);
        if (dreq) chk("data_rdata", {96'b0, data_rdata_o}, {96'b0, exp_d});
        chk("exit_valid", {127'b0, exit_valid_o}, {127'b0, exp_ev});
        chk("exit_value", {96'b0, exit_value_o}, {96'b0, ref_exit});
    endtask

    task automatic idle();
        do_op(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] ia, da, wd;
        logic [3:0]  be;
        logic        ir, dr, we;

        // Reset state
        #12;
        chk("rst_instr_rvalid", {127'b0, instr_rvalid_o}, 128'h0);
        chk("rst_instr_rdata", instr_rdata_o, 128'h0);
        chk("rst_data_rvalid", {127'b0, data_rvalid_o}, 128'h0);
        chk("rst_data_rdata", {96'b0, data_rdata_o}, 128'h0);
        chk("rst_exit_valid", {127'b0, exit_valid_o}, 128'h0);
        chk("rst_exit_value", {96'b0, exit_value_o}, 128'h0);
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;
        repeat (3) idle();

        // Fill a 1 KiB working region so every later read is of known data.
        for (int w = 0; w < 256; w++) do_op(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, w * 4, $urandom);

        // Full write, byte-enabled overwrite, read back
        do_op(1'b0, 0, 1'b1, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF);
        do_op(1'b0, 0, 1'b1, 1'b1, 4'b0001, 32'h100, 32'h000000AA);
        do_op(1'b0, 0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0);
        chk("wr_rd_const", {96'b0, data_rdata_o}, {96'b0, 32'hDEADBEAA});
        // be = 0 writes nothing but responds
        do_op(1'b0, 0, 1'b1, 1'b1, 4'b0000, 32'h100, 32'h55555555);
        do_op(1'b0, 0, 1'b1, 1'b0, 4'b0000, 32'h100, 32'h0);
        chk("be0_const", {96'b0, data_rdata_o}, {96'b0, 32'hDEADBEAA});

        // Instruction fetch of a known line at an unaligned address
        for (int w = 0; w < 4; w++)
            do_op(1'b0, 0, 1'b1, 1'b1, 4'hF, 32'h80 + w * 4,
                  {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        do_op(1'b1, 32'h84, 1'b0, 1'b0, 4'h0, 0, 0);
        chk("fetch_const", instr_rdata_o, 128'h0F0E0D0C0B0A09080706050403020100);

        // Aliasing modulo array size
        do_op(1'b0, 0, 1'b1, 1'b1, 4'hF, 32'h0040_0010, 32'h12345678);
        do_op(1'b0, 0, 1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        chk("alias_const", {96'b0, data_rdata_o}, {96'b0, 32'h12345678});

        // Exit register: pulses, value, read-as-zero, repeat pulse
        do_op(1'b0, 0, 1'b1, 1'b1, 4'hF, EXIT_A, 32'h0);
        idle();
        do_op(1'b0, 0, 1'b1, 1'b1, 4'hF, EXIT_A, 32'h5);
        chk("exit5_const", {96'b0, exit_value_o}, {96'b0, 32'h5});
        do_op(1'b0, 0, 1'b1, 1'b1, 4'hF, EXIT_A + 32'h3, 32'h5);
        do_op(1'b0, 0, 1'b1, 1'b0, 4'h0, EXIT_A, 32'h0);

        // Stdout write leaves the aliased array word (index 0) untouched
        do_op(1'b0, 0, 1'b1, 1'b1, 4'hF, STDOUT_A, 32'h41);
        do_op(1'b0, 0, 1'b1, 1'b0, 4'h0, STDOUT_A, 32'h0);
        do_op(1'b0, 0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

        // Same-cycle write and fetch of the same line returns old data
        do_op(1'b1, 32'h200, 1'b1, 1'b1, 4'hF, 32'h200, 32'hCAFEF00D);
        do_op(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 0, 0);
        chk("collide_new", {96'b0, instr_rdata_o[31:0]}, {96'b0, 32'hCAFEF00D});

        // Reset mid-transaction drops the response, array survives
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h100;
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        @(posedge clk); #1;
        data_req_i = 1'b0; instr_req_i = 1'b0;
        chk("pre_rst_rvalid", {127'b0, data_rvalid_o}, 128'h1);
        rst_ni = 1'b0; #1;
        chk("mid_rst_data_rvalid", {127'b0, data_rvalid_o}, 128'h0);
        chk("mid_rst_instr_rvalid", {127'b0, instr_rvalid_o}, 128'h0);
        chk("mid_rst_data_rdata", {96'b0, data_rdata_o}, 128'h0);
        chk("mid_rst_exit_value", {96'b0, exit_value_o}, 128'h0);
        ref_exit = '0;
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;
        idle();
        do_op(1'b1, 32'h80, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);

        // Randomized mix over the working region, with alias bits and peripherals
        for (int n = 0; n < 600; n++) begin
            ir = 1'($urandom);
            dr = ($urandom_range(0, 3) != 0);
            we = 1'($urandom);
            be = 4'($urandom);
            wd = $urandom;
            ia = ($urandom_range(0, 1023) << AW) | $urandom_range(0, 1023);
            da = ($urandom_range(0, 1023) << AW) | $urandom_range(0, 1023);
            case ($urandom_range(0, 15))
                0: da = EXIT_A | 32'($urandom_range(0, 3));
                1: da = STDOUT_A | 32'($urandom_range(0, 3));
                2: ia = da;
                default: ;
            endcase
            do_op(ir, ia, dr, we, be, da, wd);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_ram.md
# core_ram

Dual-port simulation memory for the RI5CY core model: a 128-bit-wide instruction fetch port and a 32-bit byte-enabled data port share one byte-addressed array. The data port also decodes two memory-mapped peripherals, a character output and a program-exit register; the exit register drives the harness's pass/fail reporting. The block is instantiated as `ram` beside `riscv_core` in the simulation top level.

## Interface
- ADDR_WIDTH, 22, number of byte-address bits that index the array (size = 2^ADDR_WIDTH bytes).
- clk  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- instr_req_i  in  1  instruction fetch request.
- instr_addr_i  in  32  fetch byte address.
- instr_gnt_o  out  1  fetch grant.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  128  fetch data, 16 bytes, little-endian.
- data_req_i  in  1  data request.
- data_addr_i  in  32  data byte address.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables for writes.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  data grant.
- data_rvalid_o  out  1  data response valid; also asserted for writes.
- data_rdata_o  out  32  read data.
- exit_valid_o  out  1  one-cycle pulse on a program-exit write.
- exit_value_o  out  32  last exit code written.

## Operation
- Address mapping:
  - Array index = addr[ADDR_WIDTH-1:0]; higher bits are ignored, so addresses alias modulo the array size.
  - Instruction reads ignore addr[3:0].
  - Data accesses ignore addr[1:0].
- Peripheral decode is on data_addr_i[31:2] only. Constants:
  - STDOUT_ADDR = 32'h1000_0000
  - EXIT_ADDR = 32'h2000_0000
- Data write to EXIT_ADDR:
  - The array is not written.
  - exit_value_o <= data_wdata_i, and exit_valid_o pulses.
- Data write to STDOUT_ADDR: the array is not written; behaviour is set under Configuration.
- Data read of either peripheral address returns 32'h0.
- Instruction fetches never decode peripherals; they always read the array.
- Ordinary data write: bytes with data_be_i[k]=1 are written, other bytes are unchanged.
  - data_be_i = 0 writes nothing but still produces a response.
- The array contents are not reset. The harness preloads them via hierarchical backdoor ($readmemh on dp_ram's array).

## Timing
- Grants are combinational: gnt_o = req_i on both ports. No wait states and no back-pressure.
- Responses arrive exactly 1 cycle after a request:
  - rvalid_o is registered from req_i.
  - rdata_o is registered in the same edge.
  - Back-to-back requests give back-to-back responses.
- Write response: data_rdata_o = 32'h0.
- exit_valid_o asserts in the cycle after the EXIT_ADDR write handshake, for one cycle. A repeated write pulses again.
- Same-cycle data write and instruction read of overlapping bytes: the read returns the old (pre-write) data.
- Same-cycle data read and write cannot occur (single data port).
- Reset values: instr_rvalid_o=0, instr_rdata_o=0, data_rvalid_o=0, data_rdata_o=0, exit_valid_o=0, exit_value_o=0.
- Reset asserted mid-transaction drops any pending response. The array keeps its contents.

## Configuration
- RAM_STDOUT_EN defined: a write to STDOUT_ADDR prints data_wdata_i[7:0] as a character via $write at the handshake edge.
- RAM_STDOUT_EN undefined: the write is acknowledged and discarded, with no print.
- Handshake timing is identical in both builds.

## Structure
- Package ram_pkg: STDOUT_ADDR, EXIT_ADDR, INSTR_BYTES=16, DATA_BYTES=4.
- Sub-module dp_ram:
  - byte array of 2^ADDR_WIDTH entries;
  - port A: 128-bit read-only;
  - port B: 32-bit read/write with byte enables;
  - registered read outputs.
- core_ram adds handshake, peripheral decode, exit registers and the print.

## Test plan
- Reset: hold rst_ni=0 -> all outputs 0; release, no requests -> rvalid_o stays 0.
- Data write then read: write 32'hDEADBEEF be=4'b1111 @0x100, then write 32'h000000AA be=4'b0001 @0x100, then read -> gnt same cycle as each req, rvalid 1 cycle later, rdata=32'hDEADBEAA.
- Instruction fetch: preload bytes 0x80..0x8F with 0x00..0x0F, fetch @0x84 -> rvalid next cycle, rdata=128'h0F0E..0100.
- Aliasing: write 32'h12345678 @0x0040_0010 (ADDR_WIDTH=22), read @0x10 -> 32'h12345678.
- Exit: write 0 to 0x2000_0000 -> exit_valid_o single pulse, exit_value_o=0. Write 5 -> pulse, exit_value_o=5. Read 0x2000_0000 -> 0.
- Stdout and collision:
  - With RAM_STDOUT_EN, write 32'h41 to 0x1000_0000 -> prints "A", array unchanged.
  - Write @0x200 concurrent with fetch @0x200 -> fetch returns old data.
